// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_RESET,
    S_FETCH,
    S_OUT,
    S_HALT
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES   = 4;
  localparam logic [1:0]  PC_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/fetch_pc_calc.sv
// Next-PC select for the fetch unit: sequential PC+4 or redirect target.
// A redirect arriving this cycle takes precedence over one already pending.
module fetch_pc_calc
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              pend_i,
  input  logic [ADDR_W-1:0] tgt_i,
  output logic              pend_o,
  output logic [ADDR_W-1:0] tgt_o,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic              misalign_o
);

  // Merge the live redirect with the latched one and pick the next PC
  always_comb begin
    pend_o     = redirect_valid_i | pend_i;
    tgt_o      = redirect_valid_i ? redirect_pc_i : tgt_i;
    next_pc_o  = pend_o ? tgt_o : (pc_i + ADDR_W'(INSTR_BYTES));
    misalign_o = redirect_valid_i && ((redirect_pc_i[1:0] & PC_ALIGN_MASK) != '0);
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/ack, hands out on valid/ready.
// Optional build macro FETCH_PERF_EN adds perf_fetched / perf_redirects counters.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned INSTR_W = 32
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  startpc,
  input  logic [ADDR_W-1:0]  haltpc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  currentpc,
  output logic               halted,
  output logic               misalign
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_redirects
`endif
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;
  logic               mis_q, mis_d;
  logic               pend_q, pend_d;
  logic [ADDR_W-1:0]  tgt_q, tgt_d;
  logic               req;

  logic               pend_eff;
  logic [ADDR_W-1:0]  tgt_eff;
  logic [ADDR_W-1:0]  next_pc;
  logic               redir_mis;

  fetch_pc_calc #(.ADDR_W(ADDR_W)) u_pc_calc (
    .pc_i             (pc_q),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .pend_i           (pend_q),
    .tgt_i            (tgt_q),
    .pend_o           (pend_eff),
    .tgt_o            (tgt_eff),
    .next_pc_o        (next_pc),
    .misalign_o       (redir_mis)
  );

  // State and datapath registers
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q  <= S_RESET;
      pc_q     <= '0;
      instr_q  <= '0;
      ipc_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      mis_q    <= 1'b0;
      pend_q   <= 1'b0;
      tgt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      mis_q    <= mis_d;
      pend_q   <= pend_d;
      tgt_q    <= tgt_d;
    end
  end

  // Next-state and request logic.
  // A redirect seen during S_FETCH is held pending so imem_addr stays stable
  // for the outstanding request; it is applied (and the data dropped) on ack.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    mis_d    = mis_q;
    pend_d   = pend_q;
    tgt_d    = tgt_q;
    req      = 1'b0;
    unique case (state_q)
      S_RESET: begin
        pc_d    = startpc;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (redir_mis) begin
          mis_d    = 1'b1;
          halted_d = 1'b1;
          pend_d   = 1'b0;
          state_d  = S_HALT;
        end else if (pc_q == haltpc) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          req    = 1'b1;
          pend_d = pend_eff;
          tgt_d  = tgt_eff;
          if (imem_ack) begin
            if (pend_eff) begin
              pc_d   = tgt_eff;
              pend_d = 1'b0;
            end else begin
              instr_d = imem_rdata;
              ipc_d   = pc_q;
              valid_d = 1'b1;
              state_d = S_OUT;
            end
          end
        end
      end
      S_OUT: begin
        if (redir_mis) begin
          mis_d    = 1'b1;
          halted_d = 1'b1;
          valid_d  = 1'b0;
          pend_d   = 1'b0;
          state_d  = S_HALT;
        end else begin
          pend_d = pend_eff;
          tgt_d  = tgt_eff;
          if (instr_ready) begin
            valid_d = 1'b0;
            pc_d    = next_pc;
            pend_d  = 1'b0;
            state_d = S_FETCH;
          end
        end
      end
      S_HALT: begin
        halted_d = 1'b1;
        valid_d  = 1'b0;
      end
      default: state_d = S_HALT;
    endcase
  end

  assign imem_req    = req;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign currentpc   = pc_q;
  assign halted      = halted_q;
  assign misalign    = mis_q;

`ifdef FETCH_PERF_EN
  logic        fetched_inc;
  logic        redir_inc;
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_redirects_q;

  // Event strobes: accepted instruction, redirect actually applied
  always_comb begin
    fetched_inc = (state_q == S_OUT) && !redir_mis && instr_ready;
    redir_inc   = ((state_q == S_OUT) && !redir_mis && instr_ready && pend_eff) ||
                  ((state_q == S_FETCH) && !redir_mis && (pc_q != haltpc) &&
                   imem_ack && pend_eff);
  end

  // Saturating performance counters
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      perf_fetched_q   <= '0;
      perf_redirects_q <= '0;
    end else begin
      if (fetched_inc && (perf_fetched_q != '1))
        perf_fetched_q <= perf_fetched_q + 32'd1;
      if (redir_inc && (perf_redirects_q != '1))
        perf_redirects_q <= perf_redirects_q + 32'd1;
    end
  end

  assign perf_fetched   = perf_fetched_q;
  assign perf_redirects = perf_redirects_q;
`endif

endmodule
